rom_fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the 64-word instruction ROM. It owns the program counter and drives the ROM word address each cycle. It captures the returned instruction into a 2-entry FIFO and presents it to decode through a valid/ready handshake. Branch and jump redirects flush the FIFO and reload the PC; a global stall freezes fetch.

---
 rtl/rom_fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_rom_fetch_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fetches from the 64-word ROM into a 2-entry FIFO.
// Optional misaligned-redirect trap built when FETCH_ALIGN_CHECK_EN is defined.
//
// state | meaning
// BOOT  | after reset, no fetch; moves to RUN on the next edge
// RUN   | normal fetch / redirect handling
// FAULT | misaligned redirect trapped; held until reset (FETCH_ALIGN_CHECK_EN only)
module rom_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_fault
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1} state_t;
`endif

    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [1:0]  count;
    logic [31:0] slot1_instr, slot1_pc;
    logic        push, pop, flush, fault_set;

    assign rom_addr  = {2'b00, pc[31:2]};
    assign out_valid = (count != 2'd0);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        fault_set  = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        fault_set  = 1'b1;
                        state_next = FAULT;
                    end else begin
                        pc_next = redirect_pc;
                    end
`else
                    pc_next = {redirect_pc[31:2], 2'b00};
`endif
                end else begin
                    pop  = out_valid && out_ready;
                    push = !stall && ((count < DEPTH) || pop);
                    if (push)
                        pc_next = pc + 32'd4;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            FAULT: state_next = FAULT;
`endif
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Two-slot shift FIFO: slot 0 is the head and drives out_* directly from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= 2'd0;
            out_instr   <= 32'd0;
            out_pc      <= 32'd0;
            slot1_instr <= 32'd0;
            slot1_pc    <= 32'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            if (pop && push) begin
                if (count == 2'd1) begin
                    out_instr <= rom_instr;
                    out_pc    <= pc;
                end else begin
                    out_instr   <= slot1_instr;
                    out_pc      <= slot1_pc;
                    slot1_instr <= rom_instr;
                    slot1_pc    <= pc;
                end
            end else if (pop) begin
                out_instr <= slot1_instr;
                out_pc    <= slot1_pc;
                count     <= count - 2'd1;
            end else if (push) begin
                if (count == 2'd0) begin
                    out_instr <= rom_instr;
                    out_pc    <= pc;
                end else begin
                    slot1_instr <= rom_instr;
                    slot1_pc    <= pc;
                end
                count <= count + 2'd1;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fetch_fault <= 1'b0;
        else if (fault_set)
            fetch_fault <= 1'b1;
    end
`else
    logic unused_fault_set;
    assign unused_fault_set = fault_set;
    assign fetch_fault      = 1'b0;
`endif

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Bench for rom_fetch_ctrl: directed test-plan scenarios plus random traffic against a queue model.
module tb_rom_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rom_addr, rom_instr;
    logic        stall = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid, fetch_fault;
    logic [31:0] out_instr, out_pc;

    int n_checks = 0;
    int n_fail   = 0;

    rom_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_instr(rom_instr),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // ROM contents: word i holds 32'h1000_0000 + i
    assign rom_instr = 32'h1000_0000 + {26'd0, rom_addr[5:0]};

    // Behavioural model: decoded instruction stream as queues.
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];
    bit          m_run, m_fault;
    logic [31:0] m_pc;

    function automatic logic [31:0] rom_of(input logic [31:0] byte_pc);
        return 32'h1000_0000 + ((byte_pc >> 2) % 64);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_ins.delete();
        m_run   = 0;
        m_fault = 0;
        m_pc    = 32'h0000_0000;
    endtask

    task automatic model_step(input logic s, input logic r, input logic rv, input logic [31:0] rpc);
        bit popped;
        if (!m_run && !m_fault) begin
            m_run = 1;
        end else if (m_run) begin
            if (rv) begin
                q_pc.delete();
                q_ins.delete();
`ifdef FETCH_ALIGN_CHECK_EN
                if (rpc[1:0] != 2'b00) begin
                    m_fault = 1;
                    m_run   = 0;
                end else
                    m_pc = rpc;
`else
                m_pc = rpc & 32'hFFFF_FFFC;
`endif
            end else begin
                popped = (q_pc.size() > 0) && r;
                if (popped) begin
                    void'(q_pc.pop_front());
                    void'(q_ins.pop_front());
                end
                if (!s && q_pc.size() < 2) begin
                    q_pc.push_back(m_pc);
                    q_ins.push_back(rom_of(m_pc));
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_val("out_valid", {31'd0, out_valid}, {31'd0, q_pc.size() > 0});
        if (q_pc.size() > 0) begin
            check_val("out_pc", out_pc, q_pc[0]);
            check_val("out_instr", out_instr, q_ins[0]);
        end
        check_val("rom_addr", rom_addr, m_pc >> 2);
        check_val("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    endtask

    task automatic step(input logic s, input logic r, input logic rv, input logic [31:0] rpc);
        stall          = s;
        out_ready      = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        model_step(s, r, rv, rpc);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Assert reset between edges, check async clear, release after two edges.
    task automatic do_reset();
        stall          = 0;
        redirect_valid = 0;
        out_ready      = 0;
        #1 reset = 1'b1;
        #1;
        check_val("rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_instr", out_instr, 32'd0);
        check_val("rst_pc", out_pc, 32'd0);
        check_val("rst_fault", {31'd0, fetch_fault}, 32'd0);
        check_val("rst_rom_addr", rom_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Boot stream
        step(0, 1, 0, 0);
        check_val("boot_edge1_valid", {31'd0, out_valid}, 32'd0);
        step(0, 1, 0, 0);
        check_val("boot_first_pc", out_pc, 32'h0);
        check_val("boot_first_instr", out_instr, 32'h1000_0000);
        repeat (6) step(0, 1, 0, 0);

        // Backpressure
        do_reset();
        repeat (6) step(0, 0, 0, 0);
        check_val("bp_pc_held", rom_addr, 32'd2);
        repeat (4) step(0, 1, 0, 0);

        // Redirect with full FIFO
        do_reset();
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h40);
        check_val("redir_gap_valid", {31'd0, out_valid}, 32'd0);
        step(0, 1, 0, 0);
        check_val("redir_pc", out_pc, 32'h40);
        check_val("redir_instr", out_instr, 32'h1000_0010);

        // Stall drains buffered words
        do_reset();
        repeat (3) step(0, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        check_val("stall_drained", {31'd0, out_valid}, 32'd0);
        check_val("stall_rom_addr", rom_addr, 32'd2);
        step(0, 1, 0, 0);
        check_val("stall_resume_pc", out_pc, 32'h8);

        // Wrap
        step(0, 1, 1, 32'hFFFF_FFFC);
        step(0, 1, 0, 0);
        check_val("wrap_instr", out_instr, 32'h1000_003F);
        check_val("wrap_next_addr", rom_addr, 32'd0);
        step(0, 1, 0, 0);

        // Misaligned redirect
        step(0, 1, 1, 32'h42);
`ifdef FETCH_ALIGN_CHECK_EN
        check_val("misalign_fault", {31'd0, fetch_fault}, 32'd1);
        repeat (3) step(0, 1, 1, 32'h80);
        check_val("misalign_stuck", {31'd0, out_valid}, 32'd0);
`else
        step(0, 1, 0, 0);
        check_val("misalign_pc", out_pc, 32'h40);
`endif

        // Random traffic with periodic mid-stream resets
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic        s, r, rv;
            logic [31:0] rpc;
            s   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            if ($urandom_range(0, 9) == 0)
                rpc = rpc | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0)
                rpc = 32'hFFFF_FFF0 | {28'd0, rpc[3:0]};
            step(s, r, rv, rpc);
            if (i % 150 == 149)
                do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
